// File: rtl/reg_r_pkg.sv
// Shared CPU datapath package: data width and R source-select encodings.
// The muxR encodings must stay in step with the control unit decoder.
package reg_r_pkg;

    localparam int R_WIDTH = 8;

    typedef enum logic [1:0] {
        R_SRC_INBOX = 2'b00,
        R_SRC_MEM   = 2'b01,
        R_SRC_ALU   = 2'b10,
        R_SRC_NONE  = 2'b11
    } r_src_e;

    // True for select codes that name a real source.
    function automatic logic r_src_valid(input logic [1:0] sel);
        return (sel != R_SRC_NONE);
    endfunction

endpackage

// File: rtl/reg_r_if.sv
// Bus between the control/datapath side and the R register.
// master drives sources and control and observes R; slave is the register.
interface reg_r_if #(
    parameter int WIDTH = reg_r_pkg::R_WIDTH
);
    logic [WIDTH-1:0] iInbox;
    logic [WIDTH-1:0] iAlu;
    logic [WIDTH-1:0] iMem;
    logic [1:0]       muxR;
    logic             wR;
    logic [WIDTH-1:0] R;
    logic             zero;
    logic             neg;

    modport master (
        output iInbox, iAlu, iMem, muxR, wR,
        input  R, zero, neg
    );

    modport slave (
        input  iInbox, iAlu, iMem, muxR, wR,
        output R, zero, neg
    );
endinterface

// File: rtl/reg_r_mux3.sv
// Generic 3:1 mux reusable by other datapath registers.
// Code 3 selects nothing: output is forced to zero and o_vld drops so the
// consumer can suppress its write instead of loading a bogus value.
module mux3 #(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       i_sel,
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    input  logic [WIDTH-1:0] i_d2,
    output logic [WIDTH-1:0] o_y,
    output logic             o_vld
);

    // Pick the addressed input; reserved code yields zero, never X.
    always_comb begin
        o_y   = '0;
        o_vld = 1'b1;
        case (i_sel)
            2'd0:    o_y = i_d0;
            2'd1:    o_y = i_d1;
            2'd2:    o_y = i_d2;
            default: o_vld = 1'b0;
        endcase
    end

endmodule

// File: rtl/reg_r.sv
// R (hand) register of the HRM CPU datapath. Loads inbox/mem/ALU data on a
// write-enabled rising edge and exposes zero/negative flags for jumps.
module reg_r
    import reg_r_pkg::*;
#(
    parameter int WIDTH = R_WIDTH
) (
    input  logic    clk,
    input  logic    rst,
    reg_r_if.slave  bus
);

    logic [WIDTH-1:0] w_sel;
    logic             w_sel_vld;
    logic             w_load;
    logic [WIDTH-1:0] r_val;

    // Input ordering follows the muxR encoding: d0=INBOX, d1=MEM, d2=ALU.
    mux3 #(.WIDTH(WIDTH)) u_src_mux (
        .i_sel (bus.muxR),
        .i_d0  (bus.iInbox),
        .i_d1  (bus.iMem),
        .i_d2  (bus.iAlu),
        .o_y   (w_sel),
        .o_vld (w_sel_vld)
    );

    // A write aimed at the reserved select is dropped, so R simply holds.
    assign w_load = bus.wR & w_sel_vld & r_src_valid(bus.muxR);

    // Register update; reset clears immediately and masks clock edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_val <= '0;
        else if (w_load)
            r_val <= w_sel;
    end

    assign bus.R    = r_val;
    assign bus.zero = (r_val == '0);
    assign bus.neg  = r_val[WIDTH-1];

endmodule

// File: tb/tb_reg_r.sv
// Directed self-checking bench for reg_r.
module tb_reg_r;
    import reg_r_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    reg_r_if #(.WIDTH(8)) bus ();

    reg_r #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; outputs are settled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_r(input string tag, input logic [7:0] exp_r);
        chk({tag, ".R"},    bus.R,           exp_r);
        chk({tag, ".zero"}, {7'd0, bus.zero}, {7'd0, exp_r == 8'h00});
        chk({tag, ".neg"},  {7'd0, bus.neg},  {7'd0, exp_r[7]});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst        = 1'b1;
        bus.iInbox = 8'h00;
        bus.iMem   = 8'h00;
        bus.iAlu   = 8'h00;
        bus.muxR   = R_SRC_INBOX;
        bus.wR     = 1'b0;
        #1;
        chk_r("reset_hold", 8'h00);
        tick();
        tick();
        chk_r("reset_clocked", 8'h00);

        // Release reset and load a non-zero value.
        rst      = 1'b0;
        bus.iAlu = 8'h5A;
        bus.muxR = R_SRC_ALU;
        bus.wR   = 1'b1;
        tick();
        chk_r("preload", 8'h5A);

        // Async reset between edges clears R without a clock.
        #2;
        rst = 1'b1;
        #1;
        chk_r("async_reset", 8'h00);
        #1;
        rst    = 1'b0;
        bus.wR = 1'b0;
        tick();
        tick();
        chk_r("post_reset_hold", 8'h00);

        // Source sweep.
        bus.iInbox = 8'h00;
        bus.iMem   = 8'h01;
        bus.iAlu   = 8'h03;
        bus.wR     = 1'b1;
        bus.muxR   = R_SRC_INBOX;
        tick();
        chk_r("sel_inbox", 8'h00);
        bus.muxR = R_SRC_MEM;
        tick();
        chk_r("sel_mem", 8'h01);
        bus.muxR = R_SRC_ALU;
        tick();
        chk_r("sel_alu", 8'h03);
        bus.muxR = R_SRC_NONE;
        tick();
        chk_r("sel_none", 8'h03);

        // Write disabled: R holds across changes.
        bus.wR     = 1'b0;
        bus.muxR   = R_SRC_ALU;
        bus.iAlu   = 8'h7F;
        bus.iMem   = 8'hC4;
        bus.iInbox = 8'h99;
        tick();
        bus.muxR = R_SRC_MEM;
        tick();
        bus.muxR = R_SRC_INBOX;
        tick();
        chk_r("wr_disabled", 8'h03);

        // Sign and flags.
        bus.iAlu = 8'hFF;
        bus.muxR = R_SRC_ALU;
        bus.wR   = 1'b1;
        tick();
        chk_r("neg_ff", 8'hFF);
        bus.iMem = 8'h80;
        bus.muxR = R_SRC_MEM;
        tick();
        chk_r("neg_80", 8'h80);

        // Source is sampled at the edge only.
        bus.iInbox = 8'h10;
        bus.muxR   = R_SRC_INBOX;
        tick();
        bus.iInbox = 8'h20;
        #1;
        chk_r("sample_edge", 8'h10);
        tick();
        chk_r("sample_next", 8'h20);

        // Reset held across a rising edge blocks the load.
        bus.iAlu = 8'h55;
        bus.muxR = R_SRC_ALU;
        #2;
        rst = 1'b1;
        #1;
        chk_r("midop_reset", 8'h00);
        tick();
        chk_r("midop_reset_edge", 8'h00);
        #2;
        rst = 1'b0;
        #1;
        chk_r("midop_release", 8'h00);
        tick();
        chk_r("midop_load", 8'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
